// File: rtl/msg_en_seq_pkg.sv
// Shared definitions for the multi-channel SHA-256 message-enable sequencer:
// channel state encodings, mode encodings and the default round count.
package msg_en_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } chan_state_e;

  localparam logic MODE_STICKY = 1'b0;
  localparam logic MODE_COUNT  = 1'b1;

  localparam int SHA256_ROUNDS = 64;

endpackage

// File: rtl/msg_en_seq_if.sv
// Bus between the message loader (master) and the enable sequencer (slave).
// start/stop/mode are level-sampled on every rising clock edge; there is no ready, so a one-cycle start
// is a request the sequencer may ignore (channel busy). enable/done/round/busy_any are registered outputs.
interface msg_en_seq_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 7
);

  logic [NUM_CH-1:0]       start;
  logic [NUM_CH-1:0]       stop;
  logic [NUM_CH-1:0]       mode;
  logic [NUM_CH-1:0]       enable;
  logic [NUM_CH-1:0]       done;
  logic [NUM_CH*CNT_W-1:0] round;
  logic                    busy_any;
  logic [NUM_CH*2-1:0]     state_dbg;

  modport master (
    output start, stop, mode,
    input  enable, done, round, busy_any, state_dbg
  );

  modport slave (
    input  start, stop, mode,
    output enable, done, round, busy_any, state_dbg
  );

endinterface

// File: rtl/msg_en_chan.sv
// One sequencer channel: IDLE -> RUN -> DONE -> IDLE FSM with round counter, mode latch and
// registered enable/done/round. enable_nxt exposes the next-cycle enable for the top-level busy flag.
module msg_en_chan
  import msg_en_seq_pkg::*;
#(
  parameter int ROUNDS = SHA256_ROUNDS,
  parameter int CNT_W  = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  output logic             enable,
  output logic             done,
  output logic [CNT_W-1:0] round,
  output logic             enable_nxt,
  output chan_state_e      state
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(ROUNDS - 1);

  chan_state_e      state_q, state_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] round_q, round_d;
  logic             en_q, en_d;
  logic             done_q, done_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_STICKY;
      round_q <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      round_q <= round_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  end

  // stop is tested first in every state so it beats start and the terminal count.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    round_d = '0;
    en_d    = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (!stop && start) begin
          state_d = ST_RUN;
          mode_d  = mode;
          en_d    = 1'b1;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (round_q == LAST) begin
          if (mode_q == MODE_COUNT) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            en_d = 1'b1;
          end
        end else begin
          round_d = round_q + CNT_W'(1);
          en_d    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign enable     = en_q;
  assign done       = done_q;
  assign round      = round_q;
  assign enable_nxt = en_d;
  assign state      = state_q;

endmodule

// File: rtl/msg_en_seq.sv
// Multi-channel message-enable sequencer feeding the per-channel SHA-256 compression cores.
// Replicates msg_en_chan per channel, packs the round indices and registers the aggregate busy flag.
module msg_en_seq
  import msg_en_seq_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ROUNDS = SHA256_ROUNDS,
  parameter int CNT_W  = 7
) (
  input  logic       clock,
  input  logic       reset,
  msg_en_seq_if.slave bus
);

  if (ROUNDS < 2) begin : g_bad_rounds
    $error("msg_en_seq: ROUNDS must be at least 2");
  end
  if (CNT_W < $clog2(ROUNDS)) begin : g_bad_cnt_w
    $error("msg_en_seq: CNT_W too narrow for ROUNDS");
  end

  wire  [NUM_CH-1:0]       en_w;
  wire  [NUM_CH-1:0]       dn_w;
  wire  [NUM_CH-1:0]       en_nxt;
  logic [CNT_W-1:0]        rnd_w [NUM_CH];
  chan_state_e             st_w  [NUM_CH];
  logic [NUM_CH*CNT_W-1:0] round_pk;
  logic [NUM_CH*2-1:0]     state_pk;
  logic                    busy_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    msg_en_chan #(
      .ROUNDS (ROUNDS),
      .CNT_W  (CNT_W)
    ) u_chan (
      .clock      (clock),
      .reset      (reset),
      .start      (bus.start[k]),
      .stop       (bus.stop[k]),
      .mode       (bus.mode[k]),
      .enable     (en_w[k]),
      .done       (dn_w[k]),
      .round      (rnd_w[k]),
      .enable_nxt (en_nxt[k]),
      .state      (st_w[k])
    );
  end

  always_comb begin
    round_pk = '0;
    state_pk = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      round_pk[k*CNT_W +: CNT_W] = rnd_w[k];
      state_pk[k*2 +: 2]         = st_w[k];
    end
  end

  // Built from next-state enables so busy_any lands on the same edge as enable.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) busy_q <= 1'b0;
    else        busy_q <= |en_nxt;
  end

  assign bus.enable    = en_w;
  assign bus.done      = dn_w;
  assign bus.round     = round_pk;
  assign bus.busy_any  = busy_q;
  assign bus.state_dbg = state_pk;

endmodule
